gyro_dma_rd_arbiter: RTL

- Round-robin arbiter that shares the single DMA AXI4 read-only master port (dma_r_cpu) between NREQ internal read requesters, such as the descriptor fetch and data-read engines.
- Serialises AR requests through one registered address stage.
- Tags each AR ID with the requester index and routes R beats back by that tag.
- Bounds outstanding bursts to MAX_OUT.

---
 rtl/gyro_dma_rd_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/gyro_dma_rd_arbiter.sv
// Round-robin AR arbiter and R demux for the shared DMA read master; AR issues one cycle after an uncontended s_arvalid.
// R path is combinational and zero-latency; s_arready is held low while an AR is pending or MAX_OUT bursts are in flight.
module gyro_dma_rd_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IDW     = 4,
  parameter int MAX_OUT = 4,
  localparam int TW     = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     s_arvalid,
  output logic [NREQ-1:0]     s_arready,
  input  logic [NREQ*AW-1:0]  s_araddr,
  input  logic [NREQ*8-1:0]   s_arlen,
  input  logic [NREQ*IDW-1:0] s_arid,
  output logic [NREQ-1:0]     s_rvalid,
  input  logic [NREQ-1:0]     s_rready,
  output logic [DW-1:0]       s_rdata,
  output logic [IDW-1:0]      s_rid,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [AW-1:0]       m_araddr,
  output logic [7:0]          m_arlen,
  output logic [IDW+TW-1:0]   m_arid,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DW-1:0]       m_rdata,
  input  logic [IDW+TW-1:0]   m_rid,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic [3:0]          outstanding,
  output logic                tag_err
);

  typedef enum logic {IDLE, ADDR} state_t;

  state_t          state;
  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   win_q;
  logic [3:0]      out_cnt;

  logic [TW-1:0]   win;
  logic [TW-1:0]   cand;
  logic            any_req;
  int              idx;
  logic            accept;

  logic [TW-1:0]   tag;
  logic            tag_ok;
  logic            rlast_hs;

  // Cyclic search starting at the round-robin pointer.
  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = TW'(idx);
      if (!any_req && s_arvalid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  assign accept = !rst && (state == IDLE) && any_req && (out_cnt < 4'(MAX_OUT));

  always_comb begin
    s_arready = '0;
    if (accept) s_arready[win] = 1'b1;
  end

  // Tags beyond NREQ-1 are sunk so a stray beat cannot wedge the master.
  assign tag    = m_rid[IDW +: TW];
  assign tag_ok = (tag <= TW'(NREQ - 1));

  always_comb begin
    s_rvalid = '0;
    if (tag_ok) s_rvalid[tag] = m_rvalid;
  end

  assign m_rready    = tag_ok ? s_rready[tag] : 1'b1;
  assign rlast_hs    = m_rvalid && m_rready && m_rlast;
  assign s_rid       = m_rid[IDW-1:0];
  assign s_rdata     = m_rdata;
  assign s_rresp     = m_rresp;
  assign s_rlast     = m_rlast;
  assign outstanding = out_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arid    <= '0;
      rr_ptr    <= '0;
      win_q     <= '0;
      out_cnt   <= '0;
      tag_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            m_araddr  <= s_araddr[win*AW +: AW];
            m_arlen   <= s_arlen[win*8 +: 8];
            m_arid    <= {win, s_arid[win*IDW +: IDW]};
            m_arvalid <= 1'b1;
            win_q     <= win;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            rr_ptr    <= (win_q == TW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A last beat with nothing outstanding is flagged rather than wrapping.
      if (accept && !rlast_hs) begin
        out_cnt <= out_cnt + 4'd1;
      end else if (!accept && rlast_hs) begin
        if (out_cnt == 4'd0) tag_err <= 1'b1;
        else                 out_cnt <= out_cnt - 4'd1;
      end

      if (m_rvalid && !tag_ok) tag_err <= 1'b1;
    end
  end

endmodule
